// File: rtl/fuzzy_cp_pkg.sv
// Shared types and helpers for the fuzzy coprocessor scheduler.
package fuzzy_cp_pkg;

  // Scheduler FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_RESP   = 3'd4
  } sched_state_t;

  // Largest result the coprocessor may legally return.
  localparam logic [7:0] G_MAX = 8'd100;

  // Clamp a 9-bit signed difference into the signed 8-bit range.
  function automatic logic [7:0] sat8(input logic signed [8:0] x);
    logic [7:0] r;
    if (x > 9'sd127) begin
      r = 8'h7f;
    end else if (x < -9'sd128) begin
      r = 8'h80;
    end else begin
      r = x[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Circular one-hot priority pick: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int IW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  idx,
  output logic           any
);

  // rot[i] is the request of channel (ptr + i) mod NCH
  logic [NCH-1:0] rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;

  assign rot = NCH'({req, req} >> ptr);

  // Lowest set bit of the rotated vector is the closest requester to ptr.
  always_comb begin
    off = '0;
    any = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = IW'(i);
        any = 1'b1;
      end
    end
  end

  // Undo the rotation; the sum is below 2*NCH so one conditional subtract suffices.
  assign sum = {1'b0, ptr} + {1'b0, off};
  assign idx = (sum >= (IW+1)'(NCH)) ? IW'(sum - (IW+1)'(NCH)) : sum[IW-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_onehot
      assign gnt[gi] = any && (idx == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/fuzzy_cp_scheduler.sv
// Shares one fuzzy coprocessor between NCH channels. Each channel keeps its own
// previous-T history here, so the coprocessor always runs with an external dT
// and its internal estimator never mixes streams.
module fuzzy_cp_scheduler
  import fuzzy_cp_pkg::*;
#(
  parameter int NCH          = 4,
  parameter int TIMEOUT      = 16,
  parameter int G_SAMPLE_DLY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          ch_req,
  input  logic [NCH*8-1:0]        ch_T,
  input  logic [NCH-1:0]          ch_reg_mode,
  input  logic [NCH-1:0]          ch_init,
  output logic [NCH-1:0]          ch_gnt,
  output logic                    rsp_valid,
  output logic [$clog2(NCH)-1:0]  rsp_ch,
  output logic [7:0]              rsp_G,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    cp_start,
  output logic                    cp_reg_mode,
  output logic                    cp_dt_mode,
  output logic                    cp_init,
  output logic [7:0]              cp_T,
  output logic [7:0]              cp_dT,
  input  logic                    cp_valid,
  input  logic [7:0]              cp_G
);

  localparam int IW = $clog2(NCH);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);

  sched_state_t state_reg, state_next;

  logic [IW-1:0] rr_ptr_reg;
  logic [IW-1:0] job_ch_reg;
  logic [WW-1:0] wd_cnt_reg;

  // per-channel history
  logic [7:0] t_prev_reg    [NCH];
  logic       prev_vld_reg  [NCH];
  logic [7:0] t_prev_next   [NCH];
  logic       prev_vld_next [NCH];
  logic [7:0] t_ch          [NCH];

  logic [NCH-1:0] arb_gnt;
  logic [IW-1:0]  arb_idx;
  logic           arb_any;

  logic           grant_fire;
  logic           take_g;
  logic           wd_expire;
  logic [7:0]     sel_t;
  logic [7:0]     sel_prev;
  logic           sel_vld;
  logic [7:0]     dt_calc;
  logic [7:0]     g_clamped;
  logic [IW-1:0]  rr_ptr_next;

  logic           cp_start_reg;
  logic           cp_reg_mode_reg;
  logic [7:0]     cp_T_reg;
  logic [7:0]     cp_dT_reg;
  logic           rsp_valid_reg;
  logic           rsp_err_reg;
  logic [IW-1:0]  rsp_ch_reg;
  logic [7:0]     rsp_G_reg;

  rr_arbiter #(
    .NCH (NCH),
    .IW  (IW)
  ) u_arb (
    .req (ch_req),
    .ptr (rr_ptr_reg),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // A grant only happens from IDLE; reset suppresses it so the grant pulse is never lost.
  assign grant_fire = !rst && (state_reg == ST_IDLE) && arb_any;
  assign ch_gnt     = grant_fire ? arb_gnt : '0;

  // Result capture: either the cycle after cp_valid or cp_valid itself.
  assign take_g    = (state_reg == ST_SAMPLE) ||
                     ((G_SAMPLE_DLY == 0) && (state_reg == ST_WAIT) && cp_valid);
  // cp_valid on the final watchdog cycle still counts as a completion.
  assign wd_expire = (state_reg == ST_WAIT) && !cp_valid && (wd_cnt_reg == WD_LIMIT);

  assign g_clamped = (cp_G > G_MAX) ? G_MAX : cp_G;

  // Granted channel operands; an init in the grant cycle discards the old history.
  assign sel_t    = t_ch[arb_idx];
  assign sel_prev = t_prev_reg[arb_idx];
  assign sel_vld  = prev_vld_reg[arb_idx] && !ch_init[arb_idx];
  assign dt_calc  = sel_vld ? sat8($signed({sel_t[7], sel_t}) - $signed({sel_prev[7], sel_prev}))
                            : 8'd0;

  assign rr_ptr_next = (arb_idx == IW'(NCH - 1)) ? '0 : arb_idx + IW'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      assign t_ch[gi] = ch_T[gi*8 +: 8];
      // A grant rewrites history (after any same-cycle init); a lone init just drops it.
      assign t_prev_next[gi]   = (grant_fire && arb_gnt[gi]) ? t_ch[gi] : t_prev_reg[gi];
      assign prev_vld_next[gi] = (grant_fire && arb_gnt[gi]) ? 1'b1 :
                                 (ch_init[gi] ? 1'b0 : prev_vld_reg[gi]);
    end
  endgenerate

  // Next-state logic for the job sequencer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (arb_any) state_next = ST_ISSUE;
      ST_ISSUE:  state_next = ST_WAIT;
      ST_WAIT: begin
        if (cp_valid) begin
          state_next = (G_SAMPLE_DLY != 0) ? ST_SAMPLE : ST_RESP;
        end else if (wd_cnt_reg == WD_LIMIT) begin
          state_next = ST_RESP;
        end
      end
      ST_SAMPLE: state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Per-channel previous-T and history-valid flops.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        t_prev_reg[i]   <= 8'd0;
        prev_vld_reg[i] <= 1'b0;
      end else begin
        t_prev_reg[i]   <= t_prev_next[i];
        prev_vld_reg[i] <= prev_vld_next[i];
      end
    end
  end

  // FSM, job registers, watchdog and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      rr_ptr_reg      <= '0;
      job_ch_reg      <= '0;
      wd_cnt_reg      <= '0;
      cp_start_reg    <= 1'b0;
      cp_reg_mode_reg <= 1'b0;
      cp_T_reg        <= 8'd0;
      cp_dT_reg       <= 8'd0;
      rsp_valid_reg   <= 1'b0;
      rsp_err_reg     <= 1'b0;
      rsp_ch_reg      <= '0;
      rsp_G_reg       <= 8'd0;
    end else begin
      state_reg     <= state_next;
      cp_start_reg  <= grant_fire;
      rsp_valid_reg <= take_g || wd_expire;

      if (grant_fire) begin
        job_ch_reg      <= arb_idx;
        rr_ptr_reg      <= rr_ptr_next;
        cp_T_reg        <= sel_t;
        cp_dT_reg       <= dt_calc;
        cp_reg_mode_reg <= ch_reg_mode[arb_idx];
      end

      if (state_reg == ST_ISSUE) begin
        wd_cnt_reg <= WW'(1);
      end else if ((state_reg == ST_WAIT) && (wd_cnt_reg != WD_LIMIT)) begin
        wd_cnt_reg <= wd_cnt_reg + WW'(1);
      end

      if (take_g) begin
        rsp_ch_reg  <= job_ch_reg;
        rsp_G_reg   <= g_clamped;
        rsp_err_reg <= 1'b0;
      end else if (wd_expire) begin
        rsp_ch_reg  <= job_ch_reg;
        rsp_G_reg   <= 8'd0;
        rsp_err_reg <= 1'b1;
      end
    end
  end

  assign busy        = (state_reg != ST_IDLE);
  assign cp_start    = cp_start_reg;
  assign cp_reg_mode = cp_reg_mode_reg;
  assign cp_T        = cp_T_reg;
  assign cp_dT       = cp_dT_reg;
  assign cp_dt_mode  = 1'b0;
  assign cp_init     = 1'b0;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_ch      = rsp_ch_reg;
  assign rsp_G       = rsp_G_reg;
  assign rsp_err     = rsp_err_reg;

endmodule

// File: tb/tb_fuzzy_cp_scheduler.sv
// Scoreboard bench for fuzzy_cp_scheduler with a behavioural coprocessor stub.
module tb_fuzzy_cp_scheduler;

  localparam int NCH     = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ch_req, ch_reg_mode, ch_init, ch_gnt;
  logic [31:0] ch_T;
  logic        rsp_valid, rsp_err, busy;
  logic [1:0]  rsp_ch;
  logic [7:0]  rsp_G;
  logic        cp_start, cp_reg_mode, cp_dt_mode, cp_init;
  logic [7:0]  cp_T, cp_dT;
  logic        cp_valid;
  logic [7:0]  cp_G;

  always #5 clk = ~clk;

  fuzzy_cp_scheduler #(.NCH(NCH), .TIMEOUT(TIMEOUT), .G_SAMPLE_DLY(1)) dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_T(ch_T), .ch_reg_mode(ch_reg_mode),
    .ch_init(ch_init), .ch_gnt(ch_gnt), .rsp_valid(rsp_valid), .rsp_ch(rsp_ch),
    .rsp_G(rsp_G), .rsp_err(rsp_err), .busy(busy), .cp_start(cp_start),
    .cp_reg_mode(cp_reg_mode), .cp_dt_mode(cp_dt_mode), .cp_init(cp_init),
    .cp_T(cp_T), .cp_dT(cp_dT), .cp_valid(cp_valid), .cp_G(cp_G)
  );

  // ---------------- coprocessor stub ----------------
  int         stub_lat   = 6;
  bit         stub_never = 1'b0;
  int         stub_g_ovr = -1;
  logic       stub_valid = 1'b0;
  logic [7:0] stub_g     = 8'd0;
  logic [7:0] stub_g_pend = 8'd0;
  int         stub_cnt   = 0;
  logic       start_d    = 1'b0;
  logic       late_valid = 1'b0;

  function automatic logic [7:0] stub_fn(input logic [7:0] t);
    int v;
    v = $signed(t);
    if (v < 0) v = -v;
    return 8'(v % 101);
  endfunction

  always @(posedge clk) begin
    start_d    <= cp_start;
    stub_valid <= 1'b0;
    if (cp_start && !start_d) begin
      stub_cnt    <= stub_never ? 0 : stub_lat - 1;
      stub_g_pend <= (stub_g_ovr >= 0) ? 8'(stub_g_ovr) : stub_fn(cp_T);
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        stub_valid <= 1'b1;
        stub_g     <= stub_g_pend;
      end
    end
  end

  assign cp_valid = stub_valid | late_valid;
  assign cp_G     = stub_g;

  // ---------------- scoreboard ----------------
  typedef struct { logic [7:0] t; logic [7:0] dt; logic mode; } start_exp_t;
  typedef struct { int ch; int g; int err; } rsp_exp_t;

  int         gnt_q[$];
  start_exp_t start_q[$];
  rsp_exp_t   rsp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0, grant_cyc = 0, valid_cyc = 0, rsp_count = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  int         mon_ch;
  start_exp_t mon_s;
  rsp_exp_t   mon_r;

  // Monitor: pops an expectation whenever the DUT presents a grant, a start or a response.
  always @(negedge clk) begin
    if (!rst) begin
      if (ch_gnt != 4'd0) begin
        grant_cyc = cyc;
        check("gnt_onehot", $countones(ch_gnt), 1);
        check("gnt_expected", gnt_q.size() != 0, 1);
        if (gnt_q.size() != 0) begin
          mon_ch = gnt_q.pop_front();
          check("gnt_ch", ch_gnt, 4'b0001 << mon_ch);
        end
      end
      if (cp_start) begin
        check("start_expected", start_q.size() != 0, 1);
        if (start_q.size() != 0) begin
          mon_s = start_q.pop_front();
          check("cp_T", $signed(cp_T), $signed(mon_s.t));
          check("cp_dT", $signed(cp_dT), $signed(mon_s.dt));
          check("cp_reg_mode", cp_reg_mode, mon_s.mode);
          check("cp_dt_mode", cp_dt_mode, 0);
          check("cp_init", cp_init, 0);
        end
      end
      if (cp_valid && busy) valid_cyc = cyc;
      if (rsp_valid) begin
        rsp_count++;
        check("rsp_expected", rsp_q.size() != 0, 1);
        if (rsp_q.size() != 0) begin
          mon_r = rsp_q.pop_front();
          check("rsp_ch", rsp_ch, mon_r.ch);
          check("rsp_G", rsp_G, mon_r.g);
          check("rsp_err", rsp_err, mon_r.err);
          if (mon_r.err != 0) check("rsp_timeout_latency", cyc - grant_cyc, TIMEOUT + 2);
          else                check("rsp_valid_latency", cyc - valid_cyc, 2);
          $display("rsp ch=%0d G=%0d err=%0d cycle=%0d", rsp_ch, rsp_G, rsp_err, cyc);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic expect_job(input int ch, input int t, input int mode, input int dt,
                            input int g, input int err, input bit has_rsp);
    start_exp_t s;
    rsp_exp_t   r;
    s.t = 8'(t); s.dt = 8'(dt); s.mode = mode[0];
    r.ch = ch; r.g = g; r.err = err;
    gnt_q.push_back(ch);
    start_q.push_back(s);
    if (has_rsp) rsp_q.push_back(r);
  endtask

  task automatic serve_grant();
    logic [3:0] g;
    int seen;
    g = 4'd0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ch_gnt != 4'd0) begin
        g = ch_gnt;
        seen = 1;
        break;
      end
    end
    check("grant_within_budget", seen, 1);
    @(posedge clk); #1;
    ch_req  = ch_req & ~g;
    ch_init = ch_init & ~g;
  endtask

  task automatic wait_idle();
    int seen;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        seen = 1;
        break;
      end
    end
    check("idle_within_budget", seen, 1);
  endtask

  task automatic set_ch(input int ch, input int t, input int mode, input bit init);
    ch_T[ch*8 +: 8] = 8'(t);
    ch_reg_mode[ch] = mode[0];
    ch_req[ch]      = 1'b1;
    if (init) ch_init[ch] = 1'b1;
  endtask

  task automatic do_job(input int ch, input int t, input int mode, input bit init);
    @(posedge clk); #1;
    set_ch(ch, t, mode, init);
    serve_grant();
    wait_idle();
  endtask

  task automatic check_zero(input string name);
    check({name, "_ctrl"}, {ch_gnt, busy, cp_start, cp_reg_mode, cp_dt_mode, cp_init, cp_T, cp_dT}, 0);
    check({name, "_rsp"}, {rsp_valid, rsp_ch, rsp_G, rsp_err}, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; ch_req = 4'd0; ch_init = 4'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset_outputs");
  endtask

  // ---------------- directed test sequence ----------------
  int snap;

  initial begin
    rst = 1'b1; ch_req = 4'd0; ch_T = 32'd0; ch_reg_mode = 4'd0; ch_init = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("initial_reset");

    // single channel history
    @(posedge clk); #1 ch_init[0] = 1'b1;
    @(posedge clk); #1 ch_init[0] = 1'b0;
    expect_job(0, 10, 0, 0, 10, 0, 1);  do_job(0, 10, 0, 0);
    expect_job(0, 25, 0, 15, 25, 0, 1); do_job(0, 25, 0, 0);

    // contention after reset: 0,1,2,3 then 1,3
    do_reset();
    expect_job(0, 30, 0, 0, 30, 0, 1);
    expect_job(1, -5, 0, 0, 5, 0, 1);
    expect_job(2, 7, 0, 0, 7, 0, 1);
    expect_job(3, 100, 0, 0, 100, 0, 1);
    @(posedge clk); #1;
    set_ch(0, 30, 0, 0); set_ch(1, -5, 0, 0); set_ch(2, 7, 0, 0); set_ch(3, 100, 0, 0);
    repeat (4) serve_grant();
    wait_idle();
    expect_job(1, 20, 0, 25, 20, 0, 1);
    expect_job(3, -100, 0, -128, 100, 0, 1);
    @(posedge clk); #1;
    set_ch(1, 20, 0, 0); set_ch(3, -100, 0, 0);
    repeat (2) serve_grant();
    wait_idle();

    // dT saturation on ch2 (previous T = 7)
    expect_job(2, -128, 1, -128, 27, 0, 1); do_job(2, -128, 1, 0);
    expect_job(2, 127, 0, 127, 26, 0, 1);   do_job(2, 127, 0, 0);
    expect_job(2, -128, 0, -128, 27, 0, 1); do_job(2, -128, 0, 0);

    // out-of-range coprocessor result is clamped
    stub_g_ovr = 200;
    expect_job(0, 31, 0, 1, 100, 0, 1); do_job(0, 31, 0, 0);
    stub_g_ovr = -1;

    // watchdog abort, then a late valid while idle
    stub_never = 1'b1;
    expect_job(0, 40, 0, 9, 0, 1, 1); do_job(0, 40, 0, 0);
    stub_never = 1'b0;
    snap = rsp_count;
    @(posedge clk); #1 late_valid = 1'b1;
    @(posedge clk); #1 late_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("late_valid_no_rsp", rsp_count, snap);
    check("late_valid_idle", busy, 0);

    // cp_valid on the last watchdog cycle wins
    stub_lat = 16;
    expect_job(3, -90, 0, 10, 90, 0, 1); do_job(3, -90, 0, 0);
    stub_lat = 6;

    // init coinciding with grant
    expect_job(1, 40, 0, 20, 40, 0, 1); do_job(1, 40, 0, 0);
    expect_job(1, 50, 0, 0, 50, 0, 1);  do_job(1, 50, 0, 1);
    expect_job(1, 53, 0, 3, 53, 0, 1);  do_job(1, 53, 0, 0);

    // reset while waiting on the coprocessor
    expect_job(2, 5, 0, 127, 0, 0, 0);
    @(posedge clk); #1 set_ch(2, 5, 0, 0);
    serve_grant();
    repeat (3) @(posedge clk);
    snap = rsp_count;
    do_reset();
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("reset_drops_job", rsp_count, snap);
    expect_job(2, 9, 0, 0, 9, 0, 1); do_job(2, 9, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("gnt_q_drained", gnt_q.size(), 0);
    check("start_q_drained", start_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time budget at cycle %0d", cyc);
    $fatal(1, "time budget exceeded");
  end

endmodule
